// File: rtl/sequential_decrementer.sv
// Bit-serial decrementer: subtracts one from a WIDTH-bit operand LSB-first through a
// single borrow flip-flop, with valid/ready handshakes on both the operand and the result.
module sequential_decrementer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] number,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             underflow,
    output logic             busy,
    output logic             borrow_dbg
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] opnd_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CW-1:0]    cnt;
    logic             borrow;

    logic             a_bit;
    logic             res_bit;
    logic             next_borrow;
    logic [WIDTH-1:0] next_res;

    // One full-subtractor slice with the subtrahend tied to zero; the borrow seeded
    // at accept time supplies the "minus one".
    always_comb begin
        a_bit       = opnd_sr[0];
        res_bit     = a_bit ^ borrow;
        next_borrow = ~a_bit & borrow;
        next_res    = {res_bit, res_sr[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            opnd_sr   <= '0;
            res_sr    <= '0;
            cnt       <= '0;
            borrow    <= 1'b0;
            diff      <= '0;
            underflow <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opnd_sr  <= number;
                        borrow   <= 1'b1;
                        cnt      <= '0;
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    opnd_sr <= opnd_sr >> 1;
                    res_sr  <= next_res;
                    borrow  <= next_borrow;
                    cnt     <= cnt + 1'b1;
                    // Always run all WIDTH bits even once the borrow has died out.
                    if (cnt == LAST_BIT) begin
                        state     <= DONE;
                        diff      <= next_res;
                        underflow <= next_borrow;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign borrow_dbg = borrow;

endmodule

// File: tb/tb_sequential_decrementer.sv
// Self-checking bench for sequential_decrementer: vector table, hand-written corner
// sequences and an exhaustive sweep, all results checked through a scoreboard queue.
module tb_sequential_decrementer;

    localparam int WIDTH = 4;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             uf;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] number;
        int               stall;
        logic [WIDTH-1:0] exp_diff;
        logic             exp_uf;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [WIDTH-1:0] number;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             underflow;
    logic             busy;
    logic             borrow_dbg;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   tx_count   = 0;
    int   rx_count   = 0;

    sequential_decrementer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .number     (number),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .underflow  (underflow),
        .busy       (busy),
        .borrow_dbg (borrow_dbg)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: timed out waiting for DUT at %0t", name, $time);
    endtask

    // Results are consumed on the negedge before the handshake edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                reportTimeout("unexpected_result");
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("sb_diff", 32'(diff), 32'(e.diff));
                checkOutput("sb_underflow", 32'(underflow), 32'(e.uf));
                rx_count++;
            end
        end
    end

    // Returns #1 after the accept edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] ed,
                                 input logic eu, input bit push);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            reportTimeout("in_ready");
            return;
        end
        in_valid = 1'b1;
        number   = n;
        @(posedge clk);
        if (push) begin
            sb.push_back('{diff: ed, uf: eu});
            tx_count++;
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitValid(output bit ok);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        ok = out_valid;
        if (!ok) reportTimeout("out_valid");
    endtask

    task automatic drainResult(input int stall);
        bit               ok;
        logic [WIDTH-1:0] held;
        waitValid(ok);
        if (!ok) return;
        @(posedge clk);
        #1;
        held = diff;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_diff", 32'(diff), 32'(held));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("valid_drop", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[6];
        bit   ok;
        bit   saw_valid;

        vecs[0] = '{number: 4'd5,  stall: 0, exp_diff: 4'd4,  exp_uf: 1'b0};
        vecs[1] = '{number: 4'd0,  stall: 1, exp_diff: 4'd15, exp_uf: 1'b1};
        vecs[2] = '{number: 4'd8,  stall: 2, exp_diff: 4'd7,  exp_uf: 1'b0};
        vecs[3] = '{number: 4'd3,  stall: 0, exp_diff: 4'd2,  exp_uf: 1'b0};
        vecs[4] = '{number: 4'd15, stall: 1, exp_diff: 4'd14, exp_uf: 1'b0};
        vecs[5] = '{number: 4'd1,  stall: 3, exp_diff: 4'd0,  exp_uf: 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        number    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_diff", 32'(diff), 32'd0);
        checkOutput("rst_underflow", 32'(underflow), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_borrow", 32'(borrow_dbg), 32'd0);
        reset = 1'b0;

        $display("[TB] latency with out_ready held high");
        out_ready = 1'b1;
        applyStimulus(4'd5, 4'd4, 1'b0, 1'b1);
        checkOutput("accept_busy", 32'(busy), 32'd1);
        for (int i = 1; i <= WIDTH; i++) begin
            @(posedge clk);
            #1;
            checkOutput("latency_valid", 32'(out_valid), (i == WIDTH) ? 32'd1 : 32'd0);
        end
        @(posedge clk);
        #1;
        checkOutput("latency_drop", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        $display("[TB] borrow ripple for number=8");
        applyStimulus(4'd8, 4'd7, 1'b0, 1'b1);
        checkOutput("borrow_bit0", 32'(borrow_dbg), 32'd1);
        for (int i = 1; i <= WIDTH; i++) begin
            @(posedge clk);
            #1;
            checkOutput("borrow_ripple", 32'(borrow_dbg), (i < WIDTH) ? 32'd1 : 32'd0);
        end
        drainResult(0);

        $display("[TB] vector table");
        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].number, vecs[v].exp_diff, vecs[v].exp_uf, 1'b1);
            drainResult(vecs[v].stall);
        end

        $display("[TB] stall in DONE with in_valid held");
        applyStimulus(4'd3, 4'd2, 1'b0, 1'b1);
        in_valid = 1'b1;
        number   = 4'd9;
        waitValid(ok);
        if (ok) begin
            for (int i = 0; i < 3; i++) begin
                @(posedge clk);
                #1;
                checkOutput("stall_valid", 32'(out_valid), 32'd1);
                checkOutput("stall_diff", 32'(diff), 32'd2);
                checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            checkOutput("stall_release_valid", 32'(out_valid), 32'd0);
            checkOutput("stall_release_ready", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            checkOutput("no_queued_operand", 32'(busy), 32'd0);
        end
        in_valid = 1'b0;

        $display("[TB] reset during SHIFT");
        applyStimulus(4'd6, 4'd5, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_diff", 32'(diff), 32'd0);
        saw_valid = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1'b1;
        end
        checkOutput("midrst_no_result", 32'(saw_valid), 32'd0);
        applyStimulus(4'd6, 4'd5, 1'b0, 1'b1);
        drainResult(1);

        $display("[TB] exhaustive sweep with random stalls");
        for (int n = 0; n < 16; n++) begin
            logic [WIDTH-1:0] nv;
            logic [WIDTH-1:0] ev;
            nv = WIDTH'(n);
            ev = nv - 1'b1;
            applyStimulus(nv, ev, (n == 0) ? 1'b1 : 1'b0, 1'b1);
            drainResult(int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rx_count", 32'(rx_count), 32'(tx_count));
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
